// File: rtl/riscv_sim_pkg.sv
// Shared types and defaults for the instruction sequencer slice.
// Holds the core bus widths, the canonical NOP word and the sequencer state type.
// No logic lives here.
package riscv_sim_pkg;

   localparam int          DEF_ILEN      = 32;
   localparam int          DEF_XLEN      = 64;
   // ADDI x0,x0,0 -- the architectural NOP
   localparam logic [31:0] DEF_NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/instr_store.sv
// Program store: DEPTH x ILEN words, one synchronous write port, one combinational read.
// Write lands at the clock edge; read data follows raddr with zero latency.
// No backpressure; contents are not reset.
module instr_store #(
   parameter  int ILEN  = 32,
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [ILEN-1:0] wdata,
   input  logic [AW-1:0]   raddr,
   output logic [ILEN-1:0] rdata
);

   logic [ILEN-1:0] mem [DEPTH];

   // Single write port; the array is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a preloaded program to the core, holding each word HOLD_CYCLES clocks.
// First word appears one clock after start; result captured at the end of each window.
// No backpressure: start/load are ignored while issuing, abort always wins.
module instr_sequencer
   import riscv_sim_pkg::*;
#(
   parameter  int              XLEN        = DEF_XLEN,
   parameter  int              ILEN        = DEF_ILEN,
   parameter  int              DEPTH       = 32,
   parameter  int              HOLD_CYCLES = 2,
   parameter  logic [ILEN-1:0] NOP_INSTR   = ILEN'(DEF_NOP_INSTR),
   localparam int              AW          = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_en,
   input  logic [AW-1:0]   load_addr,
   input  logic [ILEN-1:0] load_data,
   input  logic [AW:0]     prog_len,
   input  logic            start,
   input  logic            loop_en,
   input  logic            abort,
   output logic [ILEN-1:0] instruction,
   output logic            instr_valid,
   input  logic [XLEN-1:0] result,
   output logic            res_valid,
   output logic [XLEN-1:0] res_data,
   output logic [AW-1:0]   res_idx,
   output logic            busy,
   output logic            done
);

   // A 1-clock hold still needs a 1-bit counter so the compare stays well formed.
   localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);

   seq_state_t      state;
   logic [AW-1:0]   pc;
   logic [HW-1:0]   hold_cnt;
   logic [AW:0]     len_q;
   logic            loop_q;

   logic            issuing;
   logic            store_we;
   logic            window_end;
   logic            last_entry;
   logic [AW-1:0]   next_pc;
   logic [AW-1:0]   rd_addr;
   logic [ILEN-1:0] rd_data;
   logic [ILEN-1:0] start_word;
   logic [AW:0]     len_clamped;

   assign issuing     = (state == ISSUE);
   assign store_we    = load_en && !issuing;
   assign window_end  = issuing && (hold_cnt == HOLD_LAST);
   assign last_entry  = ({1'b0, pc} == (len_q - 1'b1));
   assign next_pc     = last_entry ? '0 : pc + 1'b1;
   // While issuing, look ahead to the word for the next window; otherwise entry 0 for a start.
   assign rd_addr     = issuing ? next_pc : '0;
   // A write to entry 0 in the same cycle as start must be seen by the first window.
   assign start_word  = (store_we && (load_addr == '0)) ? load_data : rd_data;
   assign len_clamped = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;

   instr_store #(
      .ILEN  (ILEN),
      .DEPTH (DEPTH)
   ) u_store (
      .clk   (clk),
      .we    (store_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Sequencer FSM with registered instruction, flags and result capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= '0;
         hold_cnt    <= '0;
         len_q       <= '0;
         loop_q      <= 1'b0;
         instruction <= NOP_INSTR;
         instr_valid <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_idx     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         if (abort) begin
            // Partial window is dropped: no capture, no res_valid.
            state       <= IDLE;
            pc          <= '0;
            hold_cnt    <= '0;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     len_q    <= len_clamped;
                     loop_q   <= loop_en;
                     pc       <= '0;
                     hold_cnt <= '0;
                     if (len_clamped == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state       <= ISSUE;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        instruction <= start_word;
                        instr_valid <= 1'b1;
                     end
                  end else if (load_en && (state == DONE)) begin
                     state <= IDLE;
                     done  <= 1'b0;
                  end
               end
               ISSUE: begin
                  if (window_end) begin
                     res_data  <= result;
                     res_idx   <= pc;
                     res_valid <= 1'b1;
                     hold_cnt  <= '0;
                     if (last_entry && !loop_q) begin
                        state       <= DONE;
                        pc          <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        instruction <= NOP_INSTR;
                        instr_valid <= 1'b0;
                     end else begin
                        pc          <= next_pc;
                        instruction <= rd_data;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
module tb_instr_sequencer;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] W0  = 32'h00A00093;  // addi x1,x0,10
   localparam logic [31:0] W1  = 32'h01408113;  // addi x2,x1,20
   localparam logic [31:0] W2  = 32'h002081B3;  // add  x3,x1,x2
   localparam logic [31:0] W3  = 32'h00500213;  // addi x4,x0,5

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   // default build
   logic        load_en, start, loop_en, abort;
   logic [4:0]  load_addr;
   logic [31:0] load_data;
   logic [5:0]  prog_len;
   logic [31:0] instruction;
   logic        instr_valid, res_valid, busy, done;
   logic [63:0] result, res_data;
   logic [4:0]  res_idx;

   // HOLD_CYCLES=1, DEPTH=4 build
   logic        load_en1, start1, loop_en1, abort1;
   logic [1:0]  load_addr1;
   logic [31:0] load_data1;
   logic [2:0]  prog_len1;
   logic [31:0] instruction1;
   logic        instr_valid1, res_valid1, busy1, done1;
   logic [63:0] result1, res_data1;
   logic [1:0]  res_idx1;

   instr_sequencer u_dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .prog_len(prog_len), .start(start), .loop_en(loop_en), .abort(abort),
      .instruction(instruction), .instr_valid(instr_valid), .result(result),
      .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx), .busy(busy), .done(done)
   );

   instr_sequencer #(.DEPTH(4), .HOLD_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset), .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1),
      .prog_len(prog_len1), .start(start1), .loop_en(loop_en1), .abort(abort1),
      .instruction(instruction1), .instr_valid(instr_valid1), .result(result1),
      .res_valid(res_valid1), .res_data(res_data1), .res_idx(res_idx1), .busy(busy1), .done(done1)
   );

   // Tiny core model: ADDI/ADD on a register file, written every valid cycle.
   logic [63:0] rf0 [32];
   logic [63:0] rf1 [32];

   function automatic logic [63:0] alu(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] imm;
      imm = {{52{ins[31]}}, ins[31:20]};
      case (ins[6:0])
         7'h13:   alu = a + imm;
         7'h33:   alu = a + b;
         default: alu = '0;
      endcase
   endfunction

   assign result  = alu(instruction,  rf0[instruction[19:15]],  rf0[instruction[24:20]]);
   assign result1 = alu(instruction1, rf1[instruction1[19:15]], rf1[instruction1[24:20]]);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            rf0[i] <= '0;
            rf1[i] <= '0;
         end
      end else begin
         if (instr_valid && instruction[11:7] != 5'd0)   rf0[instruction[11:7]]   <= result;
         if (instr_valid1 && instruction1[11:7] != 5'd0) rf1[instruction1[11:7]] <= result1;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Result scoreboards
   typedef struct {
      logic [4:0]  idx;
      logic [63:0] data;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   function automatic exp_t mk(input int idx, input logic [63:0] data);
      exp_t e;
      e.idx  = 5'(idx);
      e.data = data;
      return e;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         if (res_valid) begin
            if (q0.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL res0_unexpected: got idx=%0d data=%0d expected no res_valid", res_idx, res_data);
            end else begin
               e = q0.pop_front();
               check("res0_idx", 64'(res_idx), 64'(e.idx));
               check("res0_data", res_data, e.data);
            end
         end
         if (res_valid1) begin
            if (q1.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL res1_unexpected: got idx=%0d data=%0d expected no res_valid", res_idx1, res_data1);
            end else begin
               e = q1.pop_front();
               check("res1_idx", 64'(res_idx1), 64'(e.idx));
               check("res1_data", res_data1, e.data);
            end
         end
      end
   end

   // Table vectors: inputs for one clock, outputs expected after that edge
   typedef struct {
      logic        le;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        st;
      logic [5:0]  pl;
      logic [31:0] e_instr;
      logic        e_iv;
      logic        e_busy;
      logic        e_done;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic le, input logic [4:0] la, input logic [31:0] ld, input logic st,
                      input logic [5:0] pl, input logic [31:0] ei, input logic eiv, input logic eb, input logic ed);
      vec_t v;
      v.le = le; v.la = la; v.ld = ld; v.st = st; v.pl = pl;
      v.e_instr = ei; v.e_iv = eiv; v.e_busy = eb; v.e_done = ed;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      load_en = 0; load_addr = '0; load_data = '0; start = 0; prog_len = '0; loop_en = 0; abort = 0;
      load_en1 = 0; load_addr1 = '0; load_data1 = '0; start1 = 0; prog_len1 = '0; loop_en1 = 0; abort1 = 0;
   endtask

   task automatic check_flags(input string tag, input logic [31:0] ei, input logic eiv, input logic eb, input logic ed);
      check({tag, "_instr"}, 64'(instruction), 64'(ei));
      check({tag, "_iv"},    64'(instr_valid), 64'(eiv));
      check({tag, "_busy"},  64'(busy),        64'(eb));
      check({tag, "_done"},  64'(done),        64'(ed));
   endtask

   logic [31:0] seq3 [6];
   logic [31:0] seq4 [4];

   initial begin
      seq3[0] = W0; seq3[1] = W0; seq3[2] = W1; seq3[3] = W1; seq3[4] = W2; seq3[5] = W2;
      seq4[0] = W0; seq4[1] = W1; seq4[2] = W2; seq4[3] = W3;
      idle_in();
      reset = 1'b0;
      #1 reset = 1'b1;
      #11;
      check_flags("reset", NOP, 0, 0, 0);
      check("reset_res_valid", 64'(res_valid), 0);
      check("reset_res_data", res_data, 0);
      check("reset_res_idx", 64'(res_idx), 0);
      check("reset1_instr", 64'(instruction1), 64'(NOP));
      @(negedge clk) reset = 1'b0;
      tick();

      // Test 1/2/4b: load, issue 3 words, load in DONE, zero-length start
      add(1, 0, W0, 0, 0, NOP, 0, 0, 0);
      add(1, 1, W1, 0, 0, NOP, 0, 0, 0);
      add(1, 2, W2, 0, 0, NOP, 0, 0, 0);
      add(0, 0, 0,  1, 3, W0,  1, 1, 0);
      add(0, 0, 0,  0, 0, W0,  1, 1, 0);
      add(0, 0, 0,  0, 0, W1,  1, 1, 0);
      add(0, 0, 0,  0, 0, W1,  1, 1, 0);
      add(0, 0, 0,  0, 0, W2,  1, 1, 0);
      add(0, 0, 0,  0, 0, W2,  1, 1, 0);
      add(0, 0, 0,  0, 0, NOP, 0, 0, 1);
      add(0, 0, 0,  0, 0, NOP, 0, 0, 1);
      add(1, 3, W3, 0, 0, NOP, 0, 0, 0);
      add(0, 0, 0,  1, 0, NOP, 0, 0, 1);
      add(0, 0, 0,  0, 0, NOP, 0, 0, 1);
      add(1, 3, W3, 0, 0, NOP, 0, 0, 0);
      q0.push_back(mk(0, 10));
      q0.push_back(mk(1, 30));
      q0.push_back(mk(2, 40));
      foreach (tbl[i]) begin
         load_en = tbl[i].le; load_addr = tbl[i].la; load_data = tbl[i].ld;
         start = tbl[i].st; prog_len = tbl[i].pl;
         tick();
         check_flags($sformatf("tbl%0d", i), tbl[i].e_instr, tbl[i].e_iv, tbl[i].e_busy, tbl[i].e_done);
      end
      idle_in();
      tick();
      check("t1_queue_drained", 64'(q0.size()), 0);

      // Test 3: looping 0,1,0,1 then abort while word 1 of pass 2 is held
      start = 1; prog_len = 2; loop_en = 1;
      q0.push_back(mk(0, 10));
      q0.push_back(mk(1, 30));
      q0.push_back(mk(0, 10));
      tick();
      idle_in();
      for (int c = 1; c <= 7; c++) begin
         check($sformatf("loop_c%0d_instr", c), 64'(instruction), 64'((((c - 1) / 2) % 2) != 0 ? W1 : W0));
         check($sformatf("loop_c%0d_iv", c), 64'(instr_valid), 1);
         if (c < 7) tick();
      end
      abort = 1;
      tick();
      abort = 0;
      check_flags("abort", NOP, 0, 0, 0);
      tick(); tick();
      check("abort_queue_drained", 64'(q0.size()), 0);

      // abort beats start
      start = 1; abort = 1; prog_len = 2;
      tick();
      idle_in();
      check_flags("abort_vs_start", NOP, 0, 0, 0);

      // Test 4: load and start while busy are ignored
      start = 1; prog_len = 3;
      for (int k = 0; k < 3; k++) q0.push_back(mk(k, (k == 0) ? 10 : (k == 1) ? 30 : 40));
      tick();
      idle_in();
      tick();
      load_en = 1; load_addr = 0; load_data = 32'hDEADBEEF; start = 1; prog_len = 1;
      tick();
      idle_in();
      for (int c = 2; c < 6; c++) begin
         check($sformatf("busy_ign_c%0d_instr", c), 64'(instruction), 64'(seq3[c]));
         check($sformatf("busy_ign_c%0d_busy", c), 64'(busy), 1);
         tick();
      end
      check_flags("busy_ign_end", NOP, 0, 0, 1);
      start = 1; prog_len = 1;
      q0.push_back(mk(0, 10));
      tick();
      idle_in();
      check("readback_word0", 64'(instruction), 64'(W0));
      tick(); tick();
      check_flags("readback_end", NOP, 0, 0, 1);

      // Test 5: asynchronous reset mid-window, then replay
      start = 1; prog_len = 3;
      q0.push_back(mk(0, 10));
      tick();
      idle_in();
      tick(); tick();
      #6;
      reset = 1'b1;
      #1;
      check_flags("async_reset", NOP, 0, 0, 0);
      check("async_reset_res_valid", 64'(res_valid), 0);
      @(negedge clk) reset = 1'b0;
      tick();
      start = 1; prog_len = 3;
      for (int k = 0; k < 3; k++) q0.push_back(mk(k, (k == 0) ? 10 : (k == 1) ? 30 : 40));
      tick();
      idle_in();
      for (int c = 0; c < 6; c++) begin
         check($sformatf("replay_c%0d_instr", c), 64'(instruction), 64'(seq3[c]));
         tick();
      end
      check_flags("replay_end", NOP, 0, 0, 1);

      // Test 6: HOLD_CYCLES=1, DEPTH=4, prog_len clamped
      for (int k = 0; k < 4; k++) begin
         load_en1 = 1; load_addr1 = 2'(k); load_data1 = seq4[k];
         tick();
      end
      idle_in();
      start1 = 1; prog_len1 = 3'd7;
      q1.push_back(mk(0, 10));
      q1.push_back(mk(1, 30));
      q1.push_back(mk(2, 40));
      q1.push_back(mk(3, 5));
      tick();
      idle_in();
      check("h1_c1_instr", 64'(instruction1), 64'(W0));
      check("h1_c1_res_valid", 64'(res_valid1), 0);
      for (int c = 2; c <= 5; c++) begin
         tick();
         check($sformatf("h1_c%0d_res_valid", c), 64'(res_valid1), 1);
         check($sformatf("h1_c%0d_instr", c), 64'(instruction1), 64'((c < 5) ? seq4[c - 1] : NOP));
         check($sformatf("h1_c%0d_done", c), 64'(done1), 64'(c == 5));
      end
      tick();
      check("h1_after_res_valid", 64'(res_valid1), 0);
      check("h1_after_done", 64'(done1), 1);
      tick();
      check("q0_drained", 64'(q0.size()), 0);
      check("q1_drained", 64'(q1.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
